// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
//
// Packet-aware round-robin arbiter. It merges N_INPUTS AXI-Stream slave inputs
// onto one registered AXI-Stream master output. Once an input wins, the grant
// stays locked to it until its TLAST beat is transferred, so packets never
// interleave. The output register runs at full throughput: a new beat can be
// loaded in the same cycle the held beat leaves.
//
// Handshake: a transfer happens on a channel at a rising ACLK edge where both
// TVALID and TREADY are high. A producer holding TVALID high keeps every
// payload field stable until that transfer. TREADY may depend combinationally
// on the partner's TVALID; TVALID never waits for TREADY.
//
// Ports
//   ACLK, ARESET       clock; asynchronous active-high reset
//   S_TVALID/TREADY    per-input handshake (at most one TREADY bit high)
//   S_TDATA/TLAST/TID/TDEST  flattened slave buses, input i at [i*W +: W]
//   M_TVALID/TREADY    master handshake (M_TVALID registered)
//   M_TDATA/TLAST/TID/TDEST  registered master payload
//   GRANT              granted (IDLE) or locked (LOCKED) input index
//   BUSY               high while a packet holds the lock (FSM state view)
// -----------------------------------------------------------------------------
module axis_rr_arbiter #(
    parameter int N_INPUTS        = 4,
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int ID_WIDTH        = 4,
    parameter int DEST_WIDTH      = 4,
    localparam int SEL_W          = $clog2(N_INPUTS)
) (
    input  logic                                ACLK,
    input  logic                                ARESET,
    input  logic [N_INPUTS-1:0]                 S_TVALID,
    output logic [N_INPUTS-1:0]                 S_TREADY,
    input  logic [N_INPUTS*AXIS_DATA_WIDTH-1:0] S_TDATA,
    input  logic [N_INPUTS-1:0]                 S_TLAST,
    input  logic [N_INPUTS*ID_WIDTH-1:0]        S_TID,
    input  logic [N_INPUTS*DEST_WIDTH-1:0]      S_TDEST,
    output logic                                M_TVALID,
    input  logic                                M_TREADY,
    output logic [AXIS_DATA_WIDTH-1:0]          M_TDATA,
    output logic                                M_TLAST,
    output logic [ID_WIDTH-1:0]                 M_TID,
    output logic [DEST_WIDTH-1:0]               M_TDEST,
    output logic [SEL_W-1:0]                    GRANT,
    output logic                                BUSY
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [SEL_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]           lock_idx_q, lock_idx_d;
    logic                       m_tvalid_q, m_tvalid_d;
    logic [AXIS_DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                       m_tlast_q, m_tlast_d;
    logic [ID_WIDTH-1:0]        m_tid_q, m_tid_d;
    logic [DEST_WIDTH-1:0]      m_tdest_q, m_tdest_d;

    logic                       any_valid;
    logic [SEL_W-1:0]           sel;
    logic [SEL_W-1:0]           grant_idx;
    logic                       out_free;
    logic                       accept;
    logic [N_INPUTS-1:0]        s_tready;
    int                         idx;
    int                         gi;

    // Wrapping increment; correct for non-power-of-two N_INPUTS too.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] x);
        if (int'(x) == N_INPUTS - 1) begin
            return '0;
        end
        return x + 1'b1;
    endfunction

    // Round-robin scan starting at rr_ptr. Scanning from the far end toward
    // rr_ptr lets the closest requester overwrite earlier candidates.
    always_comb begin
        any_valid = 1'b0;
        sel       = rr_ptr_q;
        idx       = 0;
        for (int k = N_INPUTS - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % N_INPUTS;
            if (S_TVALID[idx]) begin
                any_valid = 1'b1;
                sel       = SEL_W'(idx);
            end
        end
    end

    // A locked input keeps TREADY regardless of its TVALID, so gaps inside
    // a packet hold the lock without anyone else getting through.
    always_comb begin
        grant_idx = (state_q == LOCKED) ? lock_idx_q : sel;
        out_free  = !m_tvalid_q || M_TREADY;
        s_tready  = '0;
        if (!ARESET && out_free && ((state_q == LOCKED) || any_valid)) begin
            s_tready[grant_idx] = 1'b1;
        end
        accept = |(S_TVALID & s_tready);
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        m_tvalid_d = m_tvalid_q;
        m_tdata_d  = m_tdata_q;
        m_tlast_d  = m_tlast_q;
        m_tid_d    = m_tid_q;
        m_tdest_d  = m_tdest_q;
        gi         = int'(grant_idx);
        if (accept) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = S_TDATA[gi*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
            m_tlast_d  = S_TLAST[gi];
            m_tid_d    = S_TID[gi*ID_WIDTH +: ID_WIDTH];
            m_tdest_d  = S_TDEST[gi*DEST_WIDTH +: DEST_WIDTH];
            if (S_TLAST[gi]) begin
                // Packet done: the next scan starts just past its owner.
                state_d  = IDLE;
                rr_ptr_d = next_idx(grant_idx);
            end else begin
                state_d    = LOCKED;
                lock_idx_d = grant_idx;
            end
        end else if (out_free) begin
            m_tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tid_q    <= '0;
            m_tdest_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
            m_tlast_q  <= m_tlast_d;
            m_tid_q    <= m_tid_d;
            m_tdest_q  <= m_tdest_d;
        end
    end

    assign S_TREADY = s_tready;
    assign M_TVALID = m_tvalid_q;
    assign M_TDATA  = m_tdata_q;
    assign M_TLAST  = m_tlast_q;
    assign M_TID    = m_tid_q;
    assign M_TDEST  = m_tdest_q;
    assign GRANT    = ARESET ? '0 : grant_idx;
    assign BUSY     = (state_q == LOCKED);

endmodule
